uart_rx_fifo: RTL and testbench

//   Downstream consumer of the UART receiver. Drains each completed byte through the rdy / rdy_clr

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo_mem.sv | 80 ++++++++
 rtl/uart_rx_fifo.sv | 95 +++++++++
 tb/tb_uart_rx_fifo.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared widths and capture-FSM encoding for the UART receive path.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package uart_pkg;

  localparam int UART_DATA_W = 8;

  localparam logic [0:0] CAP_IDLE = 1'b0;
  localparam logic [0:0] CAP_CLR  = 1'b1;

endpackage

`default_nettype wire

// File: rtl/uart_fifo_mem.sv
// ============================================================================
// Module  : uart_fifo_mem
// Brief   : Circular FIFO storage with occupancy counter and registered FWFT head.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic [UART_DATA_W-1:0] wr_data,
  input  logic                   pop,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  output logic [AW:0]            count,
  output logic                   full
);

  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [UART_DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]          r_wr_ptr;
  logic [AW-1:0]          r_rd_ptr;
  logic [AW:0]            r_count;
  logic [UART_DATA_W-1:0] r_rd_data;
  logic                   r_stale;
  logic [AW-1:0]          w_rd_ptr_next;
  logic                   w_load;

  always_comb begin
    w_rd_ptr_next = pop ? r_rd_ptr + AW'(1) : r_rd_ptr;
    // Head register only refreshes while an already-stored entry remains after this pop.
    w_load        = r_count > {{AW{1'b0}}, pop};
  end

  always_ff @(posedge clk) begin
    if (push) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr  <= '0;
      r_rd_ptr  <= '0;
      r_count   <= '0;
      r_rd_data <= '0;
      r_stale   <= 1'b0;
    end else begin
      if (push) begin
        r_wr_ptr <= r_wr_ptr + AW'(1);
      end
      r_rd_ptr <= w_rd_ptr_next;
      case ({push, pop})
        2'b10:   r_count <= r_count + (AW+1)'(1);
        2'b01:   r_count <= r_count - (AW+1)'(1);
        default: r_count <= r_count;
      endcase
      if (w_load) begin
        r_rd_data <= r_mem[w_rd_ptr_next];
      end
      // A byte written into the slot that becomes the head is readable one cycle later.
      r_stale <= push && (r_wr_ptr == w_rd_ptr_next);
    end
  end

  assign rd_data  = r_rd_data;
  assign rd_valid = (r_count != '0) && !r_stale;
  assign count    = r_count;
  assign full     = (r_count == c_depth);

endmodule

`default_nettype wire

// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module  : uart_rx_fifo
// Brief   : Drains UART receiver bytes via rdy/rdy_clr into an FWFT FIFO.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter  int DEPTH = 16,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [UART_DATA_W-1:0] rx_data,
  input  logic                   rx_rdy,
  output logic                   rx_rdy_clr,
  output logic [UART_DATA_W-1:0] rd_data,
  output logic                   rd_valid,
  input  logic                   rd_ready,
  output logic [AW:0]            count,
  output logic                   full,
  output logic                   overflow,
  input  logic                   ovf_clr
);

  logic [0:0] r_state;
  logic       r_rdy_clr;
  logic       r_overflow;
  logic       w_capture;
  logic       w_pop;
  logic       w_push;

  always_comb begin
    w_capture = (r_state == CAP_IDLE) && rx_rdy;
    w_pop     = rd_valid && rd_ready;
    // A same-cycle pop frees a slot, so a full FIFO can still accept.
    w_push    = w_capture && (!full || w_pop);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= CAP_IDLE;
      r_rdy_clr <= 1'b0;
    end else begin
      case (r_state)
        CAP_IDLE: begin
          if (rx_rdy) begin
            r_rdy_clr <= 1'b1;
            r_state   <= CAP_CLR;
          end
        end
        CAP_CLR: begin
          r_rdy_clr <= 1'b0;
          r_state   <= CAP_IDLE;
        end
        default: begin
          r_rdy_clr <= 1'b0;
          r_state   <= CAP_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_capture && !w_push) begin
      r_overflow <= 1'b1;
    end else if (ovf_clr) begin
      r_overflow <= 1'b0;
    end
  end

  uart_fifo_mem #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (w_push),
    .wr_data  (rx_data),
    .pop      (w_pop),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .count    (count),
    .full     (full)
  );

  assign rx_rdy_clr = r_rdy_clr;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module  : tb_uart_rx_fifo
// Brief   : Directed self-checking bench for uart_rx_fifo.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_data;
  logic       rx_rdy;
  logic       rx_rdy_clr;
  logic [7:0] rd_data;
  logic       rd_valid;
  logic       rd_ready;
  logic [4:0] count;
  logic       full;
  logic       overflow;
  logic       ovf_clr;

  int n_cmp = 0;
  int n_err = 0;
  int clr_pulses = 0;
  int p0;

  uart_rx_fifo #(.DEPTH(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .rx_data    (rx_data),
    .rx_rdy     (rx_rdy),
    .rx_rdy_clr (rx_rdy_clr),
    .rd_data    (rd_data),
    .rd_valid   (rd_valid),
    .rd_ready   (rd_ready),
    .count      (count),
    .full       (full),
    .overflow   (overflow),
    .ovf_clr    (ovf_clr)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rx_rdy_clr === 1'b1) clr_pulses++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Receiver model: rdy dropped as soon as rdy_clr is seen.
  task automatic send_byte(input logic [7:0] b);
    rx_data = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
    tick();
  endtask

  task automatic drain_one(input logic [7:0] exp, input string tag);
    int w = 0;
    while (!rd_valid && w < 8) begin
      tick();
      w++;
    end
    check({tag, "_valid"}, rd_valid, 1);
    check(tag, rd_data, exp);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; rx_data = '0; rx_rdy = 1'b0; rd_ready = 1'b0; ovf_clr = 1'b0;
    @(negedge clk);
    tick(); tick();
    check("rst_clr",   rx_rdy_clr, 0);
    check("rst_valid", rd_valid,   0);
    check("rst_count", count,      0);
    check("rst_full",  full,       0);
    check("rst_ovf",   overflow,   0);
    check("rst_data",  rd_data,    8'h00);
    rst = 1'b0;
    tick();

    // 1: single byte, rdy held for two edges
    p0 = clr_pulses;
    rx_data = 8'hA5; rx_rdy = 1'b1;
    tick();
    check("t1_clr_hi", rx_rdy_clr, 1);
    check("t1_cnt",    count,      1);
    check("t1_nvalid", rd_valid,   0);
    tick();
    rx_rdy = 1'b0;
    check("t1_clr_lo", rx_rdy_clr, 0);
    check("t1_valid",  rd_valid,   1);
    check("t1_data",   rd_data,    8'hA5);
    tick(); tick();
    check("t1_pulses", clr_pulses - p0, 1);
    check("t1_cnt2",   count,      1);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("t1_cnt0",   count,      0);
    check("t1_empty",  rd_valid,   0);
    check("t1_hold",   rd_data,    8'hA5);
    rd_ready = 1'b1;
    tick();
    rd_ready = 1'b0;
    check("underflow_cnt", count, 0);

    // 2: fill then drain with wrap
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    check("t2_full", full,  1);
    check("t2_cnt",  count, 16);
    rd_ready = 1'b1;
    for (int i = 0; i < 16; i++) begin
      check("t2_valid", rd_valid, 1);
      check("t2_data",  rd_data,  8'(i));
      tick();
    end
    rd_ready = 1'b0;
    check("t2_cnt0",  count, 0);
    check("t2_nfull", full,  0);

    // 3: overflow while full
    for (int i = 0; i < 16; i++) send_byte(8'h40 + 8'(i));
    p0 = clr_pulses;
    rx_data = 8'hEE; rx_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0;
    check("t3_clr", rx_rdy_clr, 1);
    check("t3_ovf", overflow,   1);
    check("t3_cnt", count,      16);
    tick();
    check("t3_pulses", clr_pulses - p0, 1);
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr", overflow, 0);
    rx_data = 8'hEF; rx_rdy = 1'b1; ovf_clr = 1'b1;
    tick();
    rx_rdy = 1'b0; ovf_clr = 1'b0;
    check("t3_set_wins", overflow, 1);
    tick();
    ovf_clr = 1'b1;
    tick();
    ovf_clr = 1'b0;
    check("t3_ovf_clr2", overflow, 0);

    // 4: push with simultaneous pop while full
    rx_data = 8'h77; rx_rdy = 1'b1; rd_ready = 1'b1;
    tick();
    rx_rdy = 1'b0; rd_ready = 1'b0;
    check("t4_ovf",  overflow, 0);
    check("t4_cnt",  count,    16);
    check("t4_full", full,     1);
    tick();
    for (int i = 1; i < 16; i++) drain_one(8'h40 + 8'(i), "t4_data");
    drain_one(8'h77, "t4_last");
    check("t4_cnt0", count, 0);

    // 5: back-to-back, rdy held through the clear cycle
    p0 = clr_pulses;
    rx_data = 8'hC3; rx_rdy = 1'b1;
    tick();
    rx_data = 8'h3C;
    tick();
    tick();
    rx_rdy = 1'b0;
    tick();
    tick();
    check("t5_pulses", clr_pulses - p0, 2);
    check("t5_cnt",    count, 2);
    drain_one(8'hC3, "t5_first");
    drain_one(8'h3C, "t5_second");
    check("t5_cnt0",   count, 0);

    // 6: reset during the clear cycle, with overflow pending
    for (int i = 0; i < 16; i++) send_byte(8'(i));
    send_byte(8'hEE);
    check("t6_ovf_pre", overflow, 1);
    rx_data = 8'h55; rx_rdy = 1'b1;
    tick();
    rst = 1'b1; rx_rdy = 1'b0;
    tick();
    rst = 1'b0;
    check("t6_clr",   rx_rdy_clr, 0);
    check("t6_cnt",   count,      0);
    check("t6_ovf",   overflow,   0);
    check("t6_valid", rd_valid,   0);
    tick();
    check("t6_idle_clr", rx_rdy_clr, 0);
    check("t6_idle_cnt", count,      0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

`default_nettype wire
